// File: rtl/correction_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | correction_pkg : shared types and defaults for correction_k_u     |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package correction_pkg;

  localparam int CORR_LOGQ_DEFAULT  = 64;
  localparam int CORR_LOGQH_DEFAULT = 17;
  localparam int CORR_K_DEFAULT     = 4;

  typedef struct packed {
    logic ff_in;
    logic ff_sub;
    logic ff_out;
  } correction_k_params_t;

  function automatic int correction_k_lat(input correction_k_params_t p);
    return int'(p.ff_in) + int'(p.ff_sub) + int'(p.ff_out);
  endfunction

endpackage
`default_nettype wire

// File: rtl/corr_pipe_ctrl_u.sv
`default_nettype none
// +------------------------------------------------------------------+
// | corr_pipe_ctrl_u : valid bits and global advance for N stages     |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module corr_pipe_ctrl_u #(
  parameter int N = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid_i,
  output logic in_ready_o,
  output logic out_valid_o,
  input  logic out_ready_i,
  output logic adv_o
);

  if (N == 0) begin : g_comb
    assign out_valid_o = in_valid_i;
    assign in_ready_o  = out_ready_i;
    assign adv_o       = out_ready_i;
  end else begin : g_pipe
    logic [N-1:0] valid_q;
    logic [N-1:0] valid_d;
    logic         adv;

    // The whole pipe moves together; a stalled output freezes every stage.
    assign adv = !valid_q[N-1] || out_ready_i;

    always_comb begin
      valid_d = valid_q;
      if (adv) begin
        valid_d[0] = in_valid_i;
        for (int i = 1; i < N; i++) begin
          valid_d[i] = valid_q[i-1];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        valid_q <= '0;
      end else begin
        valid_q <= valid_d;
      end
    end

    assign out_valid_o = valid_q[N-1];
    assign in_ready_o  = adv;
    assign adv_o       = adv;
  end

endmodule
`default_nettype wire

// File: rtl/correction_k_u.sv
`default_nettype none
// +------------------------------------------------------------------+
// | correction_k_u : reduces C in [0, K*q) to C mod q, q = qH*2^R + 1 |
// | Optional macro CORRECTION_K_OVF_CHECK_EN adds the ovf output.     |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module correction_k_u
  import correction_pkg::*;
#(
  parameter int LOGQ   = CORR_LOGQ_DEFAULT,
  parameter int LOGQH  = CORR_LOGQH_DEFAULT,
  parameter int K      = CORR_K_DEFAULT,
  parameter int LOGC   = LOGQ + $clog2(K),
  parameter int TAGW   = 8,
  parameter int FF_IN  = 1,
  parameter int FF_SUB = 1,
  parameter int FF_OUT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LOGQH-1:0] qH,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LOGC-1:0]  C,
  input  logic [TAGW-1:0]  in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LOGQ-1:0]  T,
  output logic [TAGW-1:0]  out_tag
`ifdef CORRECTION_K_OVF_CHECK_EN
  ,
  output logic             ovf
`endif
);

  localparam int R = LOGQ - LOGQH;
  localparam int W = LOGC + 1;
  localparam correction_k_params_t PIPE_CFG = '{
    ff_in:  (FF_IN != 0),
    ff_sub: (FF_SUB != 0),
    ff_out: (FF_OUT != 0)
  };
  localparam int LAT = correction_k_lat(PIPE_CFG);

  logic adv;

  corr_pipe_ctrl_u #(
    .N (LAT)
  ) u_ctrl (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .adv_o       (adv)
  );

  // Modulus reconstruction.
  logic [LOGQ-1:0] q;

  if (R == 0) begin : g_q_full
    assign q = qH;
  end else begin : g_q_split
    localparam logic [R-1:0] Q_LOW = R'(1);
    assign q = {qH, Q_LOW};
  end

  logic [K-1:1][W-1:0] mult;

  always_comb begin
    mult = '0;
    for (int j = 1; j < K; j++) begin
      mult[j] = W'(j) * W'(q);
    end
  end

  // Input stage.
  logic [LOGC-1:0] c_s0;
  logic [TAGW-1:0] tag_s0;

  if (FF_IN != 0) begin : g_ff_in
    logic [LOGC-1:0] c_q;
    logic [TAGW-1:0] tag_q;

    always_ff @(posedge clk) begin
      if (adv) begin
        c_q   <= C;
        tag_q <= in_tag;
      end
    end

    assign c_s0   = c_q;
    assign tag_s0 = tag_q;
  end else begin : g_no_ff_in
    assign c_s0   = C;
    assign tag_s0 = in_tag;
  end

  // Parallel trial subtractions.
  logic [K-2:0]           borrow_c;
  logic [K-2:0][LOGQ-1:0] diff_c;
  logic [W-1:0]           sub;

  always_comb begin
    borrow_c = '0;
    diff_c   = '0;
    sub      = '0;
    for (int j = 1; j < K; j++) begin
      sub           = {1'b0, c_s0} - mult[j];
      borrow_c[j-1] = sub[LOGC];
      diff_c[j-1]   = sub[LOGQ-1:0];
    end
  end

  logic ovf_c;

`ifdef CORRECTION_K_OVF_CHECK_EN
  logic [W-1:0] sub_top;

  assign sub_top = {1'b0, c_s0} - mult[K-1];
  assign ovf_c   = !sub_top[LOGC] && (sub_top[LOGC-1:0] >= LOGC'(q));
`else
  assign ovf_c   = 1'b0;
`endif

  // Subtraction register stage.
  logic [K-2:0]           borrow_s1;
  logic [K-2:0][LOGQ-1:0] diff_s1;
  logic [LOGQ-1:0]        clow_s1;
  logic [TAGW-1:0]        tag_s1;
  logic                   ovf_s1;

  if (FF_SUB != 0) begin : g_ff_sub
    logic [K-2:0]           borrow_q;
    logic [K-2:0][LOGQ-1:0] diff_q;
    logic [LOGQ-1:0]        clow_q;
    logic [TAGW-1:0]        tag_q;
    logic                   ovf_q;

    always_ff @(posedge clk) begin
      if (adv) begin
        borrow_q <= borrow_c;
        diff_q   <= diff_c;
        clow_q   <= c_s0[LOGQ-1:0];
        tag_q    <= tag_s0;
        ovf_q    <= ovf_c;
      end
    end

    assign borrow_s1 = borrow_q;
    assign diff_s1   = diff_q;
    assign clow_s1   = clow_q;
    assign tag_s1    = tag_q;
    assign ovf_s1    = ovf_q;
  end else begin : g_no_ff_sub
    assign borrow_s1 = borrow_c;
    assign diff_s1   = diff_c;
    assign clow_s1   = c_s0[LOGQ-1:0];
    assign tag_s1    = tag_s0;
    assign ovf_s1    = ovf_c;
  end

  // Largest borrow-free multiple wins; later loop iterations override earlier ones.
  logic [LOGQ-1:0] t_sel;

  always_comb begin
    t_sel = clow_s1;
    for (int j = 0; j < K-1; j++) begin
      if (!borrow_s1[j]) begin
        t_sel = diff_s1[j];
      end
    end
  end

  // Output stage.
  logic ovf_s2;

  if (FF_OUT != 0) begin : g_ff_out
    logic [LOGQ-1:0] t_q;
    logic [TAGW-1:0] tag_q;
    logic            ovf_q;

    always_ff @(posedge clk) begin
      if (adv) begin
        t_q   <= t_sel;
        tag_q <= tag_s1;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        ovf_q <= 1'b0;
      end else if (adv) begin
        ovf_q <= ovf_s1;
      end
    end

    assign T       = t_q;
    assign out_tag = tag_q;
    assign ovf_s2  = ovf_q;
  end else begin : g_no_ff_out
    assign T       = t_sel;
    assign out_tag = tag_s1;
    assign ovf_s2  = ovf_s1;
  end

`ifdef CORRECTION_K_OVF_CHECK_EN
  assign ovf = ovf_s2 && out_valid;

`ifndef SYNTHESIS
  a_no_ovf : assert property (@(posedge clk) disable iff (!rst) !(ovf && out_valid));
`endif
`else
  logic unused_ovf;
  assign unused_ovf = ovf_s2;
`endif

endmodule
`default_nettype wire

// File: tb/tb_correction_k_u.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_correction_k_u : directed and streamed checks of correction_k_u|
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_correction_k_u;

  localparam int LOGQ  = 16;
  localparam int LOGQH = 8;
  localparam int K     = 4;
  localparam int LOGC  = LOGQ + $clog2(K);
  localparam int TAGW  = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [LOGQH-1:0] qH;
  logic            in_valid, in_ready, out_valid, out_ready;
  logic [LOGC-1:0] C;
  logic [TAGW-1:0] in_tag, out_tag;
  logic [LOGQ-1:0] T;

  logic            in_valid0, in_ready0, out_valid0, out_ready0;
  logic [16:0]     C0;
  logic [TAGW-1:0] tag0_i, tag0_o;
  logic [LOGQ-1:0] T0;

  always #5 clk = ~clk;

  correction_k_u #(
    .LOGQ (LOGQ), .LOGQH (LOGQH), .K (K), .TAGW (TAGW),
    .FF_IN (1), .FF_SUB (1), .FF_OUT (1)
  ) u_dut (
    .clk (clk), .rst (rst), .qH (qH),
    .in_valid (in_valid), .in_ready (in_ready), .C (C), .in_tag (in_tag),
    .out_valid (out_valid), .out_ready (out_ready), .T (T), .out_tag (out_tag)
  );

  correction_k_u #(
    .LOGQ (LOGQ), .LOGQH (LOGQH), .K (2), .TAGW (TAGW),
    .FF_IN (0), .FF_SUB (0), .FF_OUT (0)
  ) u_dut_comb (
    .clk (clk), .rst (rst), .qH (qH),
    .in_valid (in_valid0), .in_ready (in_ready0), .C (C0), .in_tag (tag0_i),
    .out_valid (out_valid0), .out_ready (out_ready0), .T (T0), .out_tag (tag0_o)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain modular arithmetic with q built from the modulus form.
  function automatic logic [LOGQ-1:0] mod_q(input logic [LOGC-1:0] c);
    int unsigned q, cu;
    q  = int'(qH) * (32'd1 << (LOGQ - LOGQH)) + 32'd1;
    cu = 32'(c);
    return LOGQ'(cu % q);
  endfunction

  typedef struct {
    logic [LOGQ-1:0] t;
    logic [TAGW-1:0] tag;
  } exp_t;

  exp_t            sb[$];
  logic            stalled = 1'b0;
  logic [LOGQ-1:0] hold_t;
  logic [TAGW-1:0] hold_tag;

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      sb.delete();
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_T", 32'(T), 32'(hold_t));
        check("hold_tag", 32'(out_tag), 32'(hold_tag));
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got T=0x%0h tag=0x%0h, expected no beat", T, out_tag);
        end else begin
          checks--;
          e = sb.pop_front();
          check("sb_T", 32'(T), 32'(e.t));
          check("sb_tag", 32'(out_tag), 32'(e.tag));
        end
      end
      stalled  = out_valid && !out_ready;
      hold_t   = T;
      hold_tag = out_tag;
      if (in_valid && in_ready) begin
        e.t   = mod_q(C);
        e.tag = in_tag;
        sb.push_back(e);
      end
    end
  end

  task automatic single(input string name, input logic [LOGC-1:0] c,
                        input logic [TAGW-1:0] tag, input logic [LOGQ-1:0] exp_t_v);
    int n;
    @(posedge clk); #1;
    in_valid = 1'b1; C = c; in_tag = tag;
    check({name, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_latency"}, 32'(n), 32'd3);
    check({name, "_T"}, 32'(T), 32'(exp_t_v));
    check({name, "_tag"}, 32'(out_tag), 32'(tag));
  endtask

  logic done;

  initial begin
    rst = 1'b0; qH = 8'hF1; in_valid = 1'b0; out_ready = 1'b1; C = '0; in_tag = '0;
    in_valid0 = 1'b0; out_ready0 = 1'b1; C0 = '0; tag0_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b1;

    single("c_3q_m1", 18'h2D302, 8'h11, 16'hF100);
    single("c_2q",    18'h1E202, 8'h22, 16'h0000);
    single("c_small", 18'h0F100, 8'h33, 16'hF100);
    single("c_zero",  18'h00000, 8'h44, 16'h0000);
    single("c_kq_m1", 18'h3C403, 8'h55, 16'hF100);
    single("c_q",     18'h0F101, 8'h66, 16'h0000);

    // Back-to-back random stream with a randomly stalling consumer.
    done = 1'b0;
    @(posedge clk); #1;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          logic acc;
          int   g;
          in_valid = 1'b1;
          C        = LOGC'($urandom_range(0, 32'h3C403));
          in_tag   = TAGW'(i + 16);
          g = 0;
          do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            g++;
          end while (!acc && g < 200);
          if (!acc) check("stream_accept_timeout", 32'd0, 32'd1);
        end
        in_valid = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    for (int g = 0; g < 50 && sb.size() != 0; g++) @(posedge clk);
    @(posedge clk); #1;
    check("stream_drained", 32'(sb.size()), 32'd0);

    // Reset with three beats in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; C = LOGC'(18'h01000 + i); in_tag = TAGW'(8'hA0 + i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("inflight_out_valid", 32'(out_valid), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    out_ready = 1'b1;
    check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    check("rst_mid_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("rst_no_emit", 32'(out_valid), 32'd0);
    end
    single("post_rst", 18'h12345, 8'h77, 16'h3244);

    // Fully combinational K=2 instance.
    in_valid0 = 1'b1; out_ready0 = 1'b1; C0 = 17'h1E201; tag0_i = 8'h5A;
    #1;
    check("comb_out_valid", 32'(out_valid0), 32'd1);
    check("comb_T_2q_m1", 32'(T0), 32'hF100);
    check("comb_tag", 32'(tag0_o), 32'h5A);
    check("comb_in_ready_hi", 32'(in_ready0), 32'd1);
    out_ready0 = 1'b0;
    #1;
    check("comb_in_ready_lo", 32'(in_ready0), 32'd0);
    C0 = 17'h0F101;
    #1;
    check("comb_T_q", 32'(T0), 32'h0000);
    C0 = 17'h0F100;
    #1;
    check("comb_T_below_q", 32'(T0), 32'hF100);
    in_valid0 = 1'b0;
    #1;
    check("comb_out_valid_lo", 32'(out_valid0), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
